// File: rtl/mem_stage.sv
// MEM stage: registers the EX->MEM bundle, picks SRAM load data or the EX result, and aligns/extends sub-word loads.
// Outputs are combinational from the MEM register with no extra cycles; a stalled load captures its one-cycle SRAM word.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 76,
   parameter int LOAD_WD      = 5,
   parameter int MEM_TO_WB_WD = 70,
   parameter int MEM_TO_RF_WD = 38
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [5:0]              i_stall,
   input  logic [EX_TO_MEM_WD-1:0] i_ex_to_mem_bus,
   input  logic [LOAD_WD-1:0]      i_ex_load_bus,
   input  logic [31:0]             i_data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] o_mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] o_mem_to_rf_bus
);

   typedef enum logic {
      ST_LIVE = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   state_t                    r_state;
   logic [31:0]               r_hold_data;
   logic [EX_TO_MEM_WD-1:0]   r_bus;
   logic [LOAD_WD-1:0]        r_load;

   logic [31:0] w_pc;
   logic        w_ram_en;
   logic [3:0]  w_ram_wen;
   logic        w_sel_rf_res;
   logic        w_rf_we;
   logic [4:0]  w_rf_waddr;
   logic [31:0] w_ex_result;
   logic        w_is_load;
   logic        w_hold_stage;
   logic        w_bubble;
   logic [1:0]  w_addr;
   logic [31:0] w_rdata_eff;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_value;
   logic [31:0] w_rf_wdata;
   logic        w_stall_unused;

   assign w_pc         = r_bus[75:44];
   assign w_ram_en     = r_bus[43];
   assign w_ram_wen    = r_bus[42:39];
   assign w_sel_rf_res = r_bus[38];
   assign w_rf_we      = r_bus[37];
   assign w_rf_waddr   = r_bus[36:32];
   assign w_ex_result  = r_bus[31:0];

   assign w_is_load    = w_ram_en && (w_ram_wen == 4'b0000);
   assign w_bubble     = i_stall[3] && !i_stall[4];
   assign w_hold_stage = i_stall[3] && i_stall[4];

   // Only the EX/MEM and MEM/WB stall bits concern this stage.
   assign w_stall_unused = ^{i_stall[5], i_stall[2:0]};

   // The SRAM word is only guaranteed for the first MEM cycle, so a held load snapshots it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bus       <= '0;
         r_load      <= '0;
         r_hold_data <= '0;
         r_state     <= ST_LIVE;
      end else if (!i_stall[3]) begin
         r_bus   <= i_ex_to_mem_bus;
         r_load  <= i_ex_load_bus;
         r_state <= ST_LIVE;
      end else if (w_bubble) begin
         r_bus   <= '0;
         r_load  <= '0;
         r_state <= ST_LIVE;
      end else if (w_hold_stage && (r_state == ST_LIVE) && w_is_load) begin
         r_hold_data <= i_data_sram_rdata;
         r_state     <= ST_HELD;
      end
   end

   assign w_rdata_eff = (r_state == ST_HELD) ? r_hold_data : i_data_sram_rdata;
   assign w_addr      = w_ex_result[1:0];

   always_comb begin
      w_byte = w_rdata_eff[7:0];
      case (w_addr)
         2'd0: w_byte = w_rdata_eff[7:0];
         2'd1: w_byte = w_rdata_eff[15:8];
         2'd2: w_byte = w_rdata_eff[23:16];
         2'd3: w_byte = w_rdata_eff[31:24];
         default: w_byte = w_rdata_eff[7:0];
      endcase
   end

   // Halfword select ignores addr[0]; misalignment is not trapped here.
   assign w_half = w_addr[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];

   // Load flags {lb,lbu,lh,lhu,lw}; multiple set resolves lw > lh > lhu > lb > lbu.
   always_comb begin
      w_load_value = w_rdata_eff;
      if (r_load[0]) begin
         w_load_value = w_rdata_eff;
      end else if (r_load[2]) begin
         w_load_value = {{16{w_half[15]}}, w_half};
      end else if (r_load[1]) begin
         w_load_value = {16'h0000, w_half};
      end else if (r_load[4]) begin
         w_load_value = {{24{w_byte[7]}}, w_byte};
      end else if (r_load[3]) begin
         w_load_value = {24'h000000, w_byte};
      end
   end

   assign w_rf_wdata = w_sel_rf_res ? w_load_value : w_ex_result;

   assign o_mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
   assign o_mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};

endmodule
